// File: rtl/shift_issue_ctrl.sv
// ============================================================================
// Module   : shift_issue_ctrl
// Brief    : Credit-based issue/collect wrapper around a pipelined barrel
//            shifter. Optional macro: SHIFT_ISSUE_BYPASS_EN (empty-FIFO bypass).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic [WIDTH-1:0]         ReqIn,
  input  logic [$clog2(WIDTH)-1:0] ReqShiftAmount,
  input  logic                     ReqShiftIn,
  output logic [WIDTH-1:0]         ShIn,
  output logic [$clog2(WIDTH)-1:0] ShShiftAmount,
  output logic                     ShShiftIn,
  input  logic [WIDTH-1:0]         ShOut,
  output logic                     RespValid,
  input  logic                     RespReady,
  output logic [WIDTH-1:0]         RespData
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);

  logic [LATENCY-1:0] r_v;
  logic [c_CW-1:0]    r_inflight;
  logic [c_CW-1:0]    r_fifo_count;
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic            w_issue;
  logic            w_capture;
  logic            w_push;
  logic            w_pop;
  logic            w_bypass;
  logic            w_fifo_empty;
  logic [c_CW:0]   w_credit_used;
  logic [c_AW-1:0] w_wr_ptr_nxt;
  logic [c_AW-1:0] w_rd_ptr_nxt;

  // Every issued op reserves a FIFO slot until it is popped (or bypassed),
  // so the FIFO cannot overflow and ReqReady never looks at RespReady.
  assign w_credit_used = {1'b0, r_fifo_count} + {1'b0, r_inflight};
  assign ReqReady      = !Reset && (w_credit_used < (c_CW + 1)'(DEPTH));
  assign w_issue       = ReqValid && ReqReady;

  assign ShIn          = ReqIn;
  assign ShShiftAmount = ReqShiftAmount;
  assign ShShiftIn     = ReqShiftIn;

  assign w_capture     = r_v[LATENCY-1];
  assign w_fifo_empty  = (r_fifo_count == '0);

`ifdef SHIFT_ISSUE_BYPASS_EN
  assign w_bypass  = w_capture && w_fifo_empty && RespReady;
  assign RespValid = !w_fifo_empty || w_capture;
  assign RespData  = w_fifo_empty ? ShOut : r_mem[r_rd_ptr];
`else
  assign w_bypass  = 1'b0;
  assign RespValid = !w_fifo_empty;
  assign RespData  = r_mem[r_rd_ptr];
`endif

  assign w_push = w_capture && !w_bypass;
  assign w_pop  = !w_fifo_empty && RespReady;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_AW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_AW'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_v          <= '0;
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_v <= (r_v << 1) | LATENCY'(w_issue);

      if (w_issue && !w_capture) begin
        r_inflight <= r_inflight + c_CW'(1);
      end else if (!w_issue && w_capture) begin
        r_inflight <= r_inflight - c_CW'(1);
      end

      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end

      if (w_push && !w_pop) begin
        r_fifo_count <= r_fifo_count + c_CW'(1);
      end else if (w_pop && !w_push) begin
        r_fifo_count <= r_fifo_count - c_CW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && w_push) begin
      assert (r_fifo_count != c_CW'(DEPTH));
      r_mem[r_wr_ptr] <= ShOut;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_issue_ctrl.sv
// ============================================================================
// Module   : tb_shift_issue_ctrl
// Brief    : Self-checking bench for shift_issue_ctrl with a 5-stage shifter
//            model; honours SHIFT_ISSUE_BYPASS_EN for the latency check.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_issue_ctrl;

  localparam int W     = 32;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
`ifdef SHIFT_ISSUE_BYPASS_EN
  localparam int RESP_EDGES = LAT - 1;
`else
  localparam int RESP_EDGES = LAT;
`endif

  logic         Clock;
  logic         Reset;
  logic         ReqValid;
  logic         ReqReady;
  logic [W-1:0] ReqIn;
  logic [4:0]   ReqShiftAmount;
  logic         ReqShiftIn;
  logic [W-1:0] ShIn;
  logic [4:0]   ShShiftAmount;
  logic         ShShiftIn;
  logic [W-1:0] ShOut;
  logic         RespValid;
  logic         RespReady;
  logic [W-1:0] RespData;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] expq [$];
  logic [W-1:0] mon_exp;

  shift_issue_ctrl #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .ReqValid       (ReqValid),
    .ReqReady       (ReqReady),
    .ReqIn          (ReqIn),
    .ReqShiftAmount (ReqShiftAmount),
    .ReqShiftIn     (ReqShiftIn),
    .ShIn           (ShIn),
    .ShShiftAmount  (ShShiftAmount),
    .ShShiftIn      (ShShiftIn),
    .ShOut          (ShOut),
    .RespValid      (RespValid),
    .RespReady      (RespReady),
    .RespData       (RespData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Shifter model: stage k shifts by 2**k when amount bit k is set.
  logic [W-1:0] sd [LAT];
  logic [4:0]   sa [LAT];
  logic         sf [LAT];

  always @(posedge Clock) begin
    sd[0] <= ShShiftAmount[0] ? {ShIn[W-2:0], ShShiftIn} : ShIn;
    sa[0] <= ShShiftAmount;
    sf[0] <= ShShiftIn;
    for (int k = 1; k < LAT; k++) begin
      sd[k] <= sa[k-1][k] ? ((sd[k-1] << (1 << k)) | (sf[k-1] ? ~(32'hFFFFFFFF << (1 << k)) : 32'h0))
                          : sd[k-1];
      sa[k] <= sa[k-1];
      sf[k] <= sf[k-1];
    end
  end
  assign ShOut = sd[LAT-1];

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [4:0] a, input logic f);
    logic [W-1:0] ones;
    ones = ~(32'hFFFFFFFF << a);
    return (d << a) | (f ? ones : 32'h0);
  endfunction

  // Scoreboard: handshakes are judged at the negedge preceding the edge that takes them.
  always @(negedge Clock) begin
    if (Reset) begin
      expq.delete();
    end else begin
      if (RespValid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_resp: RespValid=1 data=%h with nothing outstanding", RespData);
        end else if (RespReady) begin
          checks++;
          mon_exp = expq.pop_front();
          if (RespData !== mon_exp) begin
            errors++;
            $display("FAIL resp_data: got %h expected %h", RespData, mon_exp);
          end
        end
      end
      if (ReqValid && ReqReady) begin
        expq.push_back(ref_shift(ReqIn, ReqShiftAmount, ReqShiftIn));
        checks++;
        if (expq.size() > DEPTH) begin
          errors++;
          $display("FAIL credit: outstanding %0d exceeds %0d", expq.size(), DEPTH);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || RespValid) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (expq.size() != 0 || RespValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: outstanding=%0d RespValid=%b expected 0/0", name, expq.size(), RespValid);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (ReqReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_during: got %b expected 0", ReqReady);
    end
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ReqReady=%b RespValid=%b expected 1/0", ReqReady, RespValid);
    end
  endtask

  task automatic test_single();
    int  k;
    bit  seen;
    @(posedge Clock);
    #1;
    ReqValid = 1'b1; ReqIn = 32'h000000F0; ReqShiftAmount = 5'd4; ReqShiftIn = 1'b1; RespReady = 1'b1;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(negedge Clock);
      if (RespValid) seen = 1;
      else k++;
    end
    checks++;
    if (!seen || k != RESP_EDGES) begin
      errors++;
      $display("FAIL single_latency: RespValid after %0d edges (seen=%0d) expected %0d", k, seen, RESP_EDGES);
    end
    checks++;
    if (RespData !== 32'h00000F0F) begin
      errors++;
      $display("FAIL single_data: got %h expected 00000f0f", RespData);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge Clock);
    #1;
    ReqValid = 1'b1; ReqIn = 32'h00000001; ReqShiftAmount = 5'd31; ReqShiftIn = 1'b0; RespReady = 1'b1;
    @(posedge Clock);
    #1;
    ReqIn = 32'hA5A5A5A5; ReqShiftAmount = 5'd0; ReqShiftIn = 1'b1;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!RespValid && n < 20);
    checks++;
    if (RespValid !== 1'b1 || RespData !== 32'h80000000) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%h expected 1/80000000", RespValid, RespData);
    end
    @(negedge Clock);
    checks++;
    if (RespValid !== 1'b1 || RespData !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%h expected 1/a5a5a5a5", RespValid, RespData);
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    int   idx;
    int   accepted;
    int   n;
    logic took;
    idx = 1;
    accepted = 0;
    @(posedge Clock);
    #1;
    RespReady = 1'b0;
    ReqValid = 1'b1; ReqIn = 32'(idx); ReqShiftAmount = 5'd0; ReqShiftIn = 1'b0;
    repeat (20) begin
      @(negedge Clock);
      took = ReqReady;
      @(posedge Clock);
      #1;
      if (took) begin
        accepted++;
        idx++;
        if (idx > 10) ReqValid = 1'b0;
        else ReqIn = 32'(idx);
      end
    end
    checks++;
    if (accepted != DEPTH) begin
      errors++;
      $display("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH);
    end
    @(negedge Clock);
    checks++;
    if (ReqReady !== 1'b0 || RespValid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: ReqReady=%b RespValid=%b expected 0/1", ReqReady, RespValid);
    end
    @(posedge Clock);
    #1 RespReady = 1'b1;
    n = 0;
    while (idx <= 10 && n < 60) begin
      @(negedge Clock);
      took = ReqReady && ReqValid;
      @(posedge Clock);
      #1;
      if (took) begin
        idx++;
        if (idx > 10) ReqValid = 1'b0;
        else ReqIn = 32'(idx);
      end
      n++;
    end
    ReqValid = 1'b0;
    checks++;
    if (idx != 11) begin
      errors++;
      $display("FAIL bp_issue_rest: next index %0d expected 11", idx);
    end
    drain("bp");
  endtask

  task automatic test_random();
    logic took;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge Clock);
      took = ReqValid && ReqReady;
      @(posedge Clock);
      #1;
      if (!ReqValid || took) begin
        ReqValid       = 1'($urandom_range(0, 1));
        ReqIn          = $urandom;
        ReqShiftAmount = 5'($urandom_range(0, 31));
        ReqShiftIn     = 1'($urandom_range(0, 1));
      end
      RespReady = 1'($urandom_range(0, 1));
    end
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    drain("random");
  endtask

  task automatic test_reset_mid();
    @(posedge Clock);
    #1;
    RespReady = 1'b1;
    ReqValid = 1'b1; ReqIn = 32'h11; ReqShiftAmount = 5'd1; ReqShiftIn = 1'b0;
    @(posedge Clock);
    #1 ReqIn = 32'h22;
    @(posedge Clock);
    #1 ReqIn = 32'h33;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (ReqReady !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: got %b expected 1", ReqReady);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (RespValid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet: RespValid=%b expected 0 at cycle %0d", RespValid, c);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_wrap();
    int   idx;
    int   n;
    logic took;
    idx = 0;
    n = 0;
    @(posedge Clock);
    #1;
    RespReady = 1'b0;
    ReqValid = 1'b1; ReqIn = 32'h100; ReqShiftAmount = 5'd0; ReqShiftIn = 1'b0;
    while (idx < 20 && n < 200) begin
      @(negedge Clock);
      took = ReqValid && ReqReady;
      @(posedge Clock);
      #1;
      RespReady = ~RespReady;
      if (took) begin
        idx++;
        ReqIn          = 32'h100 + 32'(idx);
        ReqShiftAmount = 5'(idx);
        ReqShiftIn     = idx[0];
      end
      n++;
    end
    ReqValid = 1'b0;
    checks++;
    if (idx != 20) begin
      errors++;
      $display("FAIL wrap_issued: got %0d expected 20", idx);
    end
    n = 0;
    while ((expq.size() != 0 || RespValid) && n < 100) begin
      @(posedge Clock);
      #1 RespReady = ~RespReady;
      n++;
    end
    RespReady = 1'b1;
    drain("wrap");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; ReqIn = '0; ReqShiftAmount = '0; ReqShiftIn = 1'b0; RespReady = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
